// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared scan codes, writer states and glyph defaults for the text buffer
package text_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] BLANK_CODE_DEF = 8'hFF;

  typedef enum logic [1:0] {CLEAR, IDLE, BREAK, EXT} state_t;

endpackage

// File: rtl/ps2_digit_lut.sv
// rtl/ps2_digit_lut.sv - maps PS/2 set-2 digit make codes to their numeric value
module ps2_digit_lut (
  input  logic [7:0] i_code,
  output logic       o_is_digit,
  output logic [3:0] o_value
);

  always_comb begin
    o_is_digit = 1'b1;
    o_value    = 4'd0;
    case (i_code)
      8'h45:   o_value = 4'd0;
      8'h16:   o_value = 4'd1;
      8'h1E:   o_value = 4'd2;
      8'h26:   o_value = 4'd3;
      8'h25:   o_value = 4'd4;
      8'h2E:   o_value = 4'd5;
      8'h36:   o_value = 4'd6;
      8'h3D:   o_value = 4'd7;
      8'h3E:   o_value = 4'd8;
      8'h46:   o_value = 4'd9;
      default: o_is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/text_buf_writer.sv
// rtl/text_buf_writer.sv - scan-code driven cursor and character RAM writer with full-screen clear
module text_buf_writer
  import text_pkg::*;
#(
  parameter int          COLS       = 70,
  parameter int          ROWS       = 8,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kb_valid,
  input  logic [7:0]        kb_code,
  output logic              kb_ready,
  input  logic              clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [2:0]        cursor_row,
  output logic              busy
);

  localparam int CELLS = ROWS * COLS;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_idx, w_idx_nx;
  logic [6:0]        r_col, w_col_nx, w_adv_col, w_ret_col;
  logic [2:0]        r_row, w_row_nx, w_adv_row, w_ret_row, w_row_inc;
  logic              r_wr_en, w_wr_en_nx;
  logic [ADDR_W-1:0] r_wr_addr, w_addr_nx, w_pos_addr;
  logic [7:0]        r_wr_data, w_data_nx;
  logic              w_is_digit, w_at_origin;
  logic [3:0]        w_digit_val;

  ps2_digit_lut u_digit_lut (
    .i_code     (kb_code),
    .o_is_digit (w_is_digit),
    .o_value    (w_digit_val)
  );

  assign kb_ready    = (r_state != CLEAR) && !clr;
  assign busy        = (r_state == CLEAR);
  assign w_pos_addr  = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);
  assign w_at_origin = (r_col == 7'd0) && (r_row == 3'd0);
  assign w_row_inc   = (r_row == 3'(ROWS - 1)) ? 3'd0 : r_row + 3'd1;

  // Cursor neighbours in reading order; the last cell advances back to the origin.
  always_comb begin
    w_adv_col = r_col + 7'd1;
    w_adv_row = r_row;
    if (r_col == 7'(COLS - 1)) begin
      w_adv_col = 7'd0;
      w_adv_row = w_row_inc;
    end
    w_ret_col = r_col - 7'd1;
    w_ret_row = r_row;
    if (r_col == 7'd0) begin
      w_ret_col = 7'(COLS - 1);
      w_ret_row = (r_row == 3'd0) ? 3'(ROWS - 1) : r_row - 3'd1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_wr_en_nx = 1'b0;
    w_addr_nx  = r_wr_addr;
    w_data_nx  = r_wr_data;
    if (clr) begin
      w_state_nx = CLEAR;
      w_idx_nx   = '0;
      w_col_nx   = 7'd0;
      w_row_nx   = 3'd0;
    end else begin
      case (r_state)
        CLEAR: begin
          w_wr_en_nx = 1'b1;
          w_addr_nx  = r_idx;
          w_data_nx  = BLANK_CODE;
          w_col_nx   = 7'd0;
          w_row_nx   = 3'd0;
          if (r_idx == ADDR_W'(CELLS - 1)) begin
            w_state_nx = IDLE;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + ADDR_W'(1);
          end
        end
        IDLE: if (kb_valid) begin
          if (kb_code == SC_BREAK) begin
            w_state_nx = BREAK;
          end else if (kb_code == SC_EXT) begin
            w_state_nx = EXT;
          end else if (w_is_digit || kb_code == SC_SPACE) begin
            w_wr_en_nx = 1'b1;
            w_addr_nx  = w_pos_addr;
            w_data_nx  = w_is_digit ? {4'd0, w_digit_val} : BLANK_CODE;
            w_col_nx   = w_adv_col;
            w_row_nx   = w_adv_row;
          end else if (kb_code == SC_ENTER) begin
            w_col_nx = 7'd0;
            w_row_nx = w_row_inc;
          end else if (kb_code == SC_BKSP && !w_at_origin) begin
            // Retreat is one linear step back, so the blanked address is simply pos-1.
            w_wr_en_nx = 1'b1;
            w_addr_nx  = w_pos_addr - ADDR_W'(1);
            w_data_nx  = BLANK_CODE;
            w_col_nx   = w_ret_col;
            w_row_nx   = w_ret_row;
          end
        end
        BREAK: if (kb_valid) begin
          w_state_nx = IDLE;
        end
        EXT: if (kb_valid) begin
          w_state_nx = IDLE;
          if (kb_code == SC_BREAK) begin
            w_state_nx = BREAK;
          end else if (kb_code == SC_LEFT && !w_at_origin) begin
            w_col_nx = w_ret_col;
            w_row_nx = w_ret_row;
          end else if (kb_code == SC_RIGHT) begin
            w_col_nx = w_adv_col;
            w_row_nx = w_adv_row;
          end
        end
        default: w_state_nx = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_idx     <= '0;
      r_col     <= 7'd0;
      r_row     <= 3'd0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_col     <= w_col_nx;
      r_row     <= w_row_nx;
      r_wr_en   <= w_wr_en_nx;
      r_wr_addr <= w_addr_nx;
      r_wr_data <= w_data_nx;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_text_buf_writer.sv
// tb/tb_text_buf_writer.sv - table-driven and randomized checks of text_buf_writer
module tb_text_buf_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 8;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_valid = 1'b0;
  logic [7:0] kb_code = 8'd0;
  logic       kb_ready;
  logic       clr = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] cursor_col;
  logic [2:0] cursor_row;
  logic       busy;

  text_buf_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10), .BLANK_CODE(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_valid   (kb_valid),
    .kb_code    (kb_code),
    .kb_ready   (kb_ready),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    int         we;
    int         addr;
    int         data;
    int         col;
    int         row;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: cursor as a linear cell index plus pending-prefix flags.
  int m_col, m_row;
  bit m_brk, m_ext;
  int digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_brk = 0; m_ext = 0;
  endtask

  task automatic model_move(input int delta);
    int lin;
    lin = (m_row * COLS + m_col + delta + CELLS) % CELLS;
    m_row = lin / COLS;
    m_col = lin % COLS;
  endtask

  task automatic model_step(input logic [7:0] c, output int we, output int addr, output int data);
    int d;
    we = 0; addr = 0; data = 0;
    d = -1;
    for (int i = 0; i < 10; i++) if (digit_codes[i] == int'(c)) d = i;
    if (m_brk) begin
      m_brk = 0;
    end else if (m_ext) begin
      m_ext = 0;
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'h6B && (m_row * COLS + m_col) != 0) model_move(-1);
      else if (c == 8'h74) model_move(1);
    end else if (c == 8'hF0) begin
      m_brk = 1;
    end else if (c == 8'hE0) begin
      m_ext = 1;
    end else if (d >= 0 || c == 8'h29) begin
      we = 1; addr = m_row * COLS + m_col; data = (d >= 0) ? d : 8'hFF;
      model_move(1);
    end else if (c == 8'h5A) begin
      m_col = 0; m_row = (m_row + 1) % ROWS;
    end else if (c == 8'h66 && (m_row * COLS + m_col) != 0) begin
      model_move(-1);
      we = 1; addr = m_row * COLS + m_col; data = 8'hFF;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int ewe, ea, ed;
    @(negedge clk);
    kb_valid = 1'b1;
    kb_code  = c;
    #1;
    chk("kb_ready", int'(kb_ready), 1);
    model_step(c, ewe, ea, ed);
    @(posedge clk);
    #1;
    kb_valid = 1'b0;
    chk("wr_en", int'(wr_en), ewe);
    if (ewe != 0) begin
      chk("wr_addr", int'(wr_addr), ea);
      chk("wr_data", int'(wr_data), ed);
    end
    chk("cursor_col", int'(cursor_col), m_col);
    chk("cursor_row", int'(cursor_row), m_row);
  endtask

  task automatic apply_table(input vec_t t[$], input string tag);
    foreach (t[i]) begin
      send(t[i].code);
      chk({tag, " tbl_we"}, int'(wr_en), t[i].we);
      if (t[i].we != 0) begin
        chk({tag, " tbl_addr"}, int'(wr_addr), t[i].addr);
        chk({tag, " tbl_data"}, int'(wr_data), t[i].data);
      end
      chk({tag, " tbl_col"}, int'(cursor_col), t[i].col);
      chk({tag, " tbl_row"}, int'(cursor_row), t[i].row);
    end
  endtask

  task automatic check_clear(input string tag);
    int n, bad;
    bit done;
    n = 0; bad = 0; done = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        if (int'(wr_addr) != n || wr_data != 8'hFF) bad++;
        n++;
      end
      if (!busy) done = 1;
    end
    chk({tag, " clear_done"}, int'(done), 1);
    chk({tag, " clear_writes"}, n, CELLS);
    chk({tag, " clear_bad_writes"}, bad, 0);
    chk({tag, " clear_ready"}, int'(kb_ready), 1);
    chk({tag, " clear_col"}, int'(cursor_col), 0);
    chk({tag, " clear_row"}, int'(cursor_row), 0);
    model_reset();
  endtask

  task automatic go_right(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'hE0);
      send(8'h74);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tq[$];
    logic [7:0] pool[18] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                             8'hF0, 8'hE0, 8'h66, 8'h5A, 8'h29, 8'h6B, 8'h74, 8'h12};
    model_reset();

    #12;
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    chk("rst col", int'(cursor_col), 0);
    chk("rst row", int'(cursor_row), 0);
    chk("rst busy", int'(busy), 1);
    chk("rst ready", int'(kb_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear("init");

    tq = {};
    tq.push_back('{8'h16, 1, 0, 1, 1, 0});
    tq.push_back('{8'hF0, 0, 0, 0, 1, 0});
    tq.push_back('{8'h16, 0, 0, 0, 1, 0});
    tq.push_back('{8'h1E, 1, 1, 2, 2, 0});
    apply_table(tq, "digits");

    go_right(67);
    tq = {};
    tq.push_back('{8'h45, 1, 69, 0, 0, 1});
    tq.push_back('{8'h66, 1, 69, 8'hFF, 69, 0});
    apply_table(tq, "rowwrap");

    repeat (7) send(8'h5A);
    go_right(69);
    tq = {};
    tq.push_back('{8'h45, 1, 559, 0, 0, 0});
    tq.push_back('{8'h66, 0, 0, 0, 0, 0});
    tq.push_back('{8'hE0, 0, 0, 0, 0, 0});
    tq.push_back('{8'h6B, 0, 0, 0, 0, 0});
    apply_table(tq, "lastcell");

    send(8'h5A);
    send(8'h5A);
    go_right(5);
    tq = {};
    tq.push_back('{8'hE0, 0, 0, 0, 5, 2});
    tq.push_back('{8'h6B, 0, 0, 0, 4, 2});
    tq.push_back('{8'hE0, 0, 0, 0, 4, 2});
    tq.push_back('{8'hF0, 0, 0, 0, 4, 2});
    tq.push_back('{8'h6B, 0, 0, 0, 4, 2});
    tq.push_back('{8'hE0, 0, 0, 0, 4, 2});
    tq.push_back('{8'h74, 0, 0, 0, 5, 2});
    tq.push_back('{8'h5A, 0, 0, 0, 0, 3});
    apply_table(tq, "arrows");

    // clr wins over a simultaneous byte
    @(negedge clk);
    clr = 1'b1;
    kb_valid = 1'b1;
    kb_code = 8'h16;
    #1;
    chk("clr ready", int'(kb_ready), 0);
    @(posedge clk);
    #1;
    chk("clr wr_en", int'(wr_en), 0);
    chk("clr busy", int'(busy), 1);
    chk("clr col", int'(cursor_col), 0);
    chk("clr row", int'(cursor_row), 0);
    @(negedge clk);
    clr = 1'b0;
    kb_valid = 1'b0;
    check_clear("clr");

    // reset in the middle of a clear
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("midclr wr_en", int'(wr_en), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async wr_en", int'(wr_en), 0);
    chk("async wr_addr", int'(wr_addr), 0);
    chk("async busy", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    check_clear("rst2");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        @(negedge clk);
        kb_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle wr_en", int'(wr_en), 0);
      end else if ($urandom_range(0, 9) < 1) begin
        send(8'($urandom));
      end else begin
        send(pool[$urandom_range(0, 17)]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buf_writer.md
Name: text_buf_writer

Overview:
- Writer side of the character display buffer.
- Consumes PS/2 set-2 scan-code bytes from the keyboard receiver through a valid/ready handshake, and tracks make/break/extended prefixes.
- Maintains a text cursor and issues single-cycle writes of glyph codes into the character RAM that the VGA renderer reads.
- Glyph codes 0..9 select digits; BLANK_CODE selects an empty cell.

Parameters:
- COLS, 70, characters per row (560 px / 8 px cell)
- ROWS, 8, text rows
- ADDR_W, 10, character RAM address width; must satisfy 2^ADDR_W >= ROWS*COLS
- BLANK_CODE, 8'hFF, glyph code for an empty cell

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- kb_valid  in  1  kb_code holds a received scan byte
- kb_code  in  8  scan-code byte
- kb_ready  out  1  block accepts a byte this cycle; combinational = (state!=CLEAR) && !clr
- clr  in  1  single-cycle request to blank the screen and home the cursor
- wr_en  out  1  character RAM write strobe, one cycle per write
- wr_addr  out  ADDR_W  write address = cursor_row*COLS + cursor_col
- wr_data  out  8  glyph code
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  3  current row, 0..ROWS-1
- busy  out  1  high while in CLEAR

Behaviour:
- Interface: one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset values:
  - state=CLEAR, clear index=0
  - wr_en=0, wr_addr=0, wr_data=0
  - cursor_col=0, cursor_row=0
  - busy=1
- Byte acceptance: a byte is accepted on a rising edge with kb_valid && kb_ready. Unaccepted bytes must be held by the source.
- Registered outputs: every write is registered. wr_en is high in the cycle after acceptance, with wr_addr/wr_data valid in that cycle. The cursor updates on the same edge. wr_en is never high two cycles from one byte. A new byte may be accepted while wr_en is high.
- CLEAR state:
  - One write per cycle of BLANK_CODE to addresses 0..ROWS*COLS-1, ascending.
  - The last write is at address ROWS*COLS-1; then busy=0 and state moves to IDLE.
  - Cursor is forced to (0,0).
  - Entered from reset, or from any non-CLEAR state when clr=1.
  - clr beats kb_valid in the same cycle: the byte is not accepted.
  - clr during CLEAR restarts the index at 0.
- IDLE state:
  - F0 -> BREAK.
  - E0 -> EXT.
  - Digit make codes 45,16,1E,26,25,2E,36,3D,3E,46 -> write 0..9 at the cursor, then advance.
  - 29 (space) -> write BLANK_CODE, then advance.
  - 5A (enter) -> col=0, row=row+1 (wrapping), no write.
  - 66 (backspace):
    - At (0,0): no-op, no write.
    - Otherwise retreat (col 0 moves to col COLS-1 of row-1), then write BLANK_CODE at the new position. The address is the retreated one.
  - All other bytes are ignored.
- BREAK state: the next accepted byte is discarded; return to IDLE. Releases never write.
- EXT state:
  - F0 -> BREAK.
  - 6B (left) -> retreat without write; no-op at (0,0).
  - 74 (right) -> advance without write.
  - Any other byte -> IDLE, ignored.
- Advance rule: col=COLS-1 wraps to col 0, row+1. Row ROWS-1 wraps to row 0, so the last cell advances to (0,0).
- Arithmetic: wr_addr is computed unsigned at ADDR_W bits; no overflow is possible given the parameter constraint.
- Reset mid-write: an asserted rst_n=0 clears wr_en immediately (asynchronous) and the full clear restarts.

Decomposition:
- Package text_pkg:
  - scan-code localparams: SC_BREAK=F0, SC_EXT=E0, SC_BKSP=66, SC_ENTER=5A, SC_SPACE=29, SC_LEFT=6B, SC_RIGHT=74
  - state enum {CLEAR, IDLE, BREAK, EXT}
  - BLANK_CODE default
- Sub-module ps2_digit_lut: combinational; outputs is_digit and a 4-bit value for kb_code. Reused by future hex-entry blocks.

Test Plan:
- Release rst_n with kb_valid=0 -> busy=1, exactly 560 writes of FF to addresses 0..559, then busy=0, kb_ready=1, cursor (0,0).
- Send 16, F0, 16, 1E -> two writes: (addr 0, data 1) then (addr 1, data 2). No write for F0 16. Cursor ends (0,2).
- Cursor at (0,69), send 45 -> write addr 69 data 0, cursor (1,0). Cursor at (7,69), send 45 -> write addr 559, cursor (0,0).
- Cursor at (1,0), send 66 -> write addr 69 data FF, cursor (0,69). Cursor at (0,0), send 66 -> no write, cursor unchanged.
- Send E0 6B, E0 F0 6B, E0 74 from (2,5) -> cursor (2,4) then (2,5). No writes. Send 5A -> cursor (3,0).
- Assert clr in the same cycle as kb_valid=1 with code 16 -> byte not accepted (kb_ready=0), full clear runs, cursor (0,0). Pull rst_n low mid-clear -> wr_en drops immediately and the clear restarts from addr 0.
